// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle controller.
//   state_e   - controller states
//   opclass_e - instruction class latched in DECODE
//   OPC_*     - recognised opcodes, ALUOP_* - ALU control classes
//   is_legal/op_class - opcode decode helpers
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_BRANCH, S_WB, S_IDLE, S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
  } opclass_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_legal(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // Undecodable opcodes map to OP_R; callers gate with is_legal().
  function automatic opclass_e op_class(input logic [6:0] opc);
    case (opc)
      OPC_I:      return OP_I;
      OPC_LOAD:   return OP_LOAD;
      OPC_STORE:  return OP_STORE;
      OPC_BRANCH: return OP_BRANCH;
      default:    return OP_R;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timer.sv
// ctrl_timer: clearable up-counter with terminal-count compare.
//   clk_i, reset_i - clock, async active-high reset
//   clr_i          - synchronous clear (wins over en_i)
//   en_i           - count enable
//   tc_i           - terminal count value
//   hit_o          - count currently equals tc_i
module ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign hit_o = (cnt_q == tc_i);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle processor control FSM.
//   clk, reset (async, active-high), run (execution enable),
//   power (gates startpc), opcode (sampled in DECODE),
//   mem_ready (memory completion) -> datapath controls alusrc, mem2reg,
//   regwrite, memread, memwrite, branch, writepc, startpc, aluop[1:0],
//   and fault (halted in FAULT).
// Parameters: MEM_TIMEOUT (0 = no timeout), IDLE_CYCLES (0..15).
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap undecodable
// opcodes into FAULT; otherwise they return the controller to START.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       power,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       alusrc,
  output logic       mem2reg,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       branch,
  output logic       writepc,
  output logic       startpc,
  output logic [1:0] aluop,
  output logic       fault
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0] IDLE_TC = (IDLE_CYCLES > 0) ? 4'(IDLE_CYCLES - 1) : 4'd0;
  // Where an instruction goes on completion; IDLE is skipped entirely at 0.
  localparam state_e DONE_ST = (IDLE_CYCLES == 0) ? S_FETCH : S_IDLE;

  state_e   state_q;
  opclass_e cls_q;
  logic     in_mem, wait_hit, idle_hit, mem_to;

  assign in_mem = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Held clear outside MEM_*, so every memory access starts from 0.
  ctrl_timer #(.W(WAIT_W)) u_wait (
    .clk_i(clk), .reset_i(reset),
    .clr_i(!in_mem), .en_i(in_mem && !mem_ready),
    .tc_i(WAIT_TC), .hit_o(wait_hit)
  );

  ctrl_timer #(.W(4)) u_idle (
    .clk_i(clk), .reset_i(reset),
    .clr_i(state_q != S_IDLE), .en_i(state_q == S_IDLE),
    .tc_i(IDLE_TC), .hit_o(idle_hit)
  );

  // mem_ready is checked first in the FSM, so it wins a tie with this.
  assign mem_to = (MEM_TIMEOUT != 0) && wait_hit && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      cls_q   <= OP_R;
    end else if (power && !run && state_q != S_FAULT) begin
      state_q <= S_START;
    end else begin
      case (state_q)
        S_START:  state_q <= S_FETCH;
        S_FETCH:  if (run) state_q <= S_DECODE;
        S_DECODE: begin
          if (is_legal(opcode)) begin
            cls_q <= op_class(opcode);
            case (op_class(opcode))
              OP_R:              state_q <= S_EXEC_R;
              OP_I:              state_q <= S_EXEC_I;
              OP_LOAD, OP_STORE: state_q <= S_ADDR;
              default:           state_q <= S_BRANCH;
            endcase
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_q <= S_FAULT;
`else
            state_q <= S_START;
`endif
          end
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_WB;
        S_ADDR:   state_q <= (cls_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready)   state_q <= S_WB;
          else if (mem_to) state_q <= S_FAULT;
        end
        S_MEM_WR: begin
          if (mem_ready)   state_q <= DONE_ST;
          else if (mem_to) state_q <= S_FAULT;
        end
        S_BRANCH, S_WB: state_q <= DONE_ST;
        S_IDLE:   if (idle_hit) state_q <= S_FETCH;
        S_FAULT:  state_q <= S_FAULT;
        default:  state_q <= S_START;
      endcase
    end
  end

  always_comb begin
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    writepc  = 1'b0;
    startpc  = 1'b0;
    aluop    = ALUOP_ADD;
    fault    = 1'b0;
    case (state_q)
      S_START:  startpc = power;
      S_FETCH:  begin writepc = 1'b1; startpc = power; end
      S_EXEC_R: aluop = ALUOP_FUNCT;
      S_EXEC_I: begin aluop = ALUOP_FUNCT; alusrc = 1'b1; end
      S_ADDR:   begin aluop = ALUOP_ADD; alusrc = 1'b1; end
      S_MEM_RD: begin memread = 1'b1; alusrc = 1'b1; end
      S_MEM_WR: begin memwrite = 1'b1; alusrc = 1'b1; end
      S_BRANCH: begin aluop = ALUOP_CMP; branch = 1'b1; end
      S_WB:     begin regwrite = 1'b1; mem2reg = (cls_q == OP_LOAD); end
      S_FAULT:  fault = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max memory wait cycles before fault; 0 disables the timeout.
REQ-002 SHALL have parameter IDLE_CYCLES, default 1: idle cycles between instruction completion and the next FETCH (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  execution enable.
REQ-006 SHALL have port power  input  1  processor powered; gates startpc.
REQ-007 SHALL have port opcode  input  7  instruction opcode, sampled in DECODE.
REQ-008 SHALL have port mem_ready  input  1  data memory completion handshake.
REQ-009 SHALL have ports alusrc, mem2reg, regwrite, memread, memwrite, branch, writepc, startpc  output  1 each  datapath controls.
REQ-010 SHALL have port aluop  output  2  ALU control class: 00 add, 01 compare, 10 funct-decoded.
REQ-011 SHALL have port fault  output  1  controller halted in FAULT.

Function
REQ-012 SHALL implement states START, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, BRANCH, WB, IDLE, FAULT.
REQ-013 SHALL drive outputs combinationally from state plus the latched op class; every output not listed for a state SHALL be 0.
REQ-014 SHALL use START -> FETCH unconditionally, with startpc=power.
REQ-015 SHALL hold FETCH until run=1, then go to DECODE; writepc=1 and startpc=power in FETCH.
REQ-016 SHALL decode in DECODE: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> ADDR; 1100011 -> BRANCH; any other value per REQ-028.
REQ-017 SHALL latch the op class (R, I, LOAD, STORE, BRANCH) in DECODE; later opcode changes SHALL have no effect until the next DECODE.
REQ-018 SHALL drive EXEC_R: aluop=10, then WB. EXEC_I: aluop=10, alusrc=1, then WB.
REQ-019 SHALL drive ADDR: aluop=00, alusrc=1, then MEM_RD for LOAD or MEM_WR for STORE.
REQ-020 SHALL drive MEM_RD: memread=1, alusrc=1; MEM_WR: memwrite=1, alusrc=1; each state is held until mem_ready=1.
REQ-021 SHALL exit MEM_RD on mem_ready to WB, and MEM_WR on mem_ready to IDLE (or FETCH if IDLE_CYCLES=0).
REQ-022 SHALL clear the wait counter on MEM_* entry and increment it each cycle mem_ready=0; at count==MEM_TIMEOUT with mem_ready=0, SHALL go to FAULT. mem_ready wins a same-cycle tie.
REQ-023 SHALL drive BRANCH: aluop=01, branch=1, then IDLE (or FETCH if IDLE_CYCLES=0).
REQ-024 SHALL drive WB: regwrite=1, mem2reg=1 only for LOAD, then IDLE (or FETCH if IDLE_CYCLES=0).
REQ-025 SHALL stay in IDLE exactly IDLE_CYCLES cycles, then go to FETCH.
REQ-026 SHALL synchronously force START when power=1 and run=0, from any state except FAULT; this aborts any memory access.
REQ-027 SHALL hold all controls at 0 and fault=1 in FAULT, exiting only on reset.

Configuration
REQ-028 SHALL, with macro CTRL_ILLEGAL_TRAP_EN defined, send an undecodable opcode from DECODE to FAULT; without it, SHALL return to START with fault never set by illegal opcodes.

Reset
REQ-029 SHALL, on reset, asynchronously set state=START, counters=0, op class=R, fault=0; all outputs SHALL be 0 except startpc=power.

Structure
REQ-030 SHALL put the state enum, op class enum, opcode constants and aluop constants in shared package ctrl_pkg.
REQ-031 SHALL implement the wait/idle counting in one sub-module ctrl_timer (clearable up-counter with terminal-count compare), instantiated twice.

Verification
REQ-032 SHALL test: IDLE_CYCLES=1, run=1, opcode=0110011 -> START,FETCH,DECODE,EXEC_R,WB,IDLE,FETCH; regwrite exactly 1 cycle; aluop=10 in EXEC_R.
REQ-033 SHALL test: opcode=0000011, mem_ready rising 3 cycles after MEM_RD entry -> memread high 4 cycles, then WB with regwrite=1, mem2reg=1.
REQ-034 SHALL test: MEM_TIMEOUT=4, opcode=0100011, mem_ready=0 -> memwrite high 5 cycles, then fault=1 with all controls 0, held until reset.
REQ-035 SHALL test: opcode=1111111 -> with CTRL_ILLEGAL_TRAP_EN, fault=1 next cycle; without it, START next cycle and fault=0.
REQ-036 SHALL test: power=1, run drops to 0 during MEM_RD -> START next cycle, memread=0, startpc=1.
REQ-037 SHALL test: opcode changes 0000011 -> 0110011 after DECODE -> load sequence completes unchanged, mem2reg=1 in WB.
